// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: core load/store port, DMA/debug loader
// port and the single data-memory port. The arbiter uses the slave view;
// whatever drives requests and models the memory uses the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Core port
  logic              C_REQ;
  logic              C_WE;
  logic [ADDR_W-1:0] C_ADDR;
  logic [DATA_W-1:0] C_WDATA;
  logic [DATA_W-1:0] C_RDATA;
  logic              C_STALL;
  // DMA / debug loader port
  logic              D_REQ;
  logic              D_WE;
  logic [ADDR_W-1:0] D_ADDR;
  logic [DATA_W-1:0] D_WDATA;
  logic [DATA_W-1:0] D_RDATA;
  logic              D_ACK;
  // Data memory port
  logic              M_EN;
  logic              M_WE;
  logic [ADDR_W-1:0] M_ADDR;
  logic [DATA_W-1:0] M_WDATA;
  logic [DATA_W-1:0] M_RDATA;

  modport slave (
    input  C_REQ, C_WE, C_ADDR, C_WDATA,
    output C_RDATA, C_STALL,
    input  D_REQ, D_WE, D_ADDR, D_WDATA,
    output D_RDATA, D_ACK,
    output M_EN, M_WE, M_ADDR, M_WDATA,
    input  M_RDATA
  );

  modport master (
    output C_REQ, C_WE, C_ADDR, C_WDATA,
    input  C_RDATA, C_STALL,
    output D_REQ, D_WE, D_ADDR, D_WDATA,
    input  D_RDATA, D_ACK,
    input  M_EN, M_WE, M_ADDR, M_WDATA,
    output M_RDATA
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port (sync write, 1-cycle registered
// read) between the core load/store path and a DMA/debug loader.
// Core has fixed priority. With DMEM_ARB_STARVE_EN defined, a 4-bit wait
// counter forces a DMA grant once DMA has waited MAX_WAIT cycles; without
// it, DMA is served only when the core is not requesting.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CORE_RD, DMA_DONE} state_t;

  state_t            state, state_nxt;
  logic              gnt_core, gnt_dma;
  logic              dma_force;
  logic              dma_rd;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  logic [3:0] wait_cnt;

  // Count cycles DMA sits ungranted; saturate at the limit, clear on grant or drop.
  always_ff @(posedge CLK) begin
    if (RESET || !bus.D_REQ || gnt_dma) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign dma_force = (wait_cnt == WAIT_MAX);
`else
  // Strict core priority: MAX_WAIT is never below 1, so this tie-off is always 0.
  assign dma_force = (MAX_WAIT == 0);
`endif

  // State register; reset abandons any in-flight read or DMA completion.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Remember whether the DMA access in flight is a read, to qualify D_RDATA.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dma_rd <= 1'b0;
    end else if (gnt_dma) begin
      dma_rd <= !bus.D_WE;
    end
  end

  // Arbitration, memory port drive, stall/ack outputs and next state.
  always_comb begin
    gnt_core  = 1'b0;
    gnt_dma   = 1'b0;
    state_nxt = IDLE;
    if (state == IDLE && !RESET) begin
      if (dma_force && bus.D_REQ) begin
        gnt_dma = 1'b1;
      end else if (bus.C_REQ) begin
        gnt_core = 1'b1;
      end else if (bus.D_REQ) begin
        gnt_dma = 1'b1;
      end
    end

    if (gnt_dma) begin
      state_nxt = DMA_DONE;
    end else if (gnt_core && !bus.C_WE) begin
      state_nxt = CORE_RD;
    end

    sel_addr    = gnt_dma ? bus.D_ADDR  : bus.C_ADDR;
    sel_wdata   = gnt_dma ? bus.D_WDATA : bus.C_WDATA;
    bus.M_EN    = gnt_core || gnt_dma;
    bus.M_WE    = (gnt_core && bus.C_WE) || (gnt_dma && bus.D_WE);
    bus.M_ADDR  = sel_addr;
    bus.M_WDATA = sel_wdata;

    // Core is frozen unless its write is taken now or its read data is here.
    if (RESET) begin
      bus.C_STALL = bus.C_REQ;
    end else begin
      bus.C_STALL = bus.C_REQ && !(gnt_core && bus.C_WE) && (state != CORE_RD);
    end

    bus.C_RDATA = '0;
    bus.D_RDATA = '0;
    bus.D_ACK   = 1'b0;
    if (!RESET && state == CORE_RD) begin
      bus.C_RDATA = bus.M_RDATA;
    end
    if (!RESET && state == DMA_DONE) begin
      bus.D_ACK = 1'b1;
      if (dma_rd) begin
        bus.D_RDATA = bus.M_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: cycle vectors from a table plus hand-built
// starvation sequences; read data is checked through a scoreboard fed by a
// reference copy of memory contents.
module tb_dmem_arbiter;

  logic CLK;
  logic RESET;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Data memory: synchronous write, registered read.
  logic [31:0] mem [0:255];
  always @(posedge CLK) begin
    if (bus.M_EN) begin
      if (bus.M_WE) mem[bus.M_ADDR[9:2]] <= bus.M_WDATA;
      else          bus.M_RDATA <= mem[bus.M_ADDR[9:2]];
    end
  end

  typedef struct {
    bit          rst;
    bit          creq;
    bit          cwe;
    logic [31:0] caddr;
    logic [31:0] cwd;
    bit          dreq;
    bit          dwe;
    logic [31:0] daddr;
    logic [31:0] dwd;
    bit          stall;
    int          gnt;   // 0 none, 1 core, 2 DMA
    bit          dack;
  } vec_t;

  typedef struct {
    bit          is_core;
    bit          is_rd;
    logic [31:0] data;
  } sb_t;

  sb_t         sb [$];
  logic [31:0] ref_mem [0:255];
  bit          core_pend = 1'b0;
  bit          dma_pend  = 1'b0;
  int          nvec  = 0;
  int          nchk  = 0;
  int          nfail = 0;

  function automatic vec_t mk(bit rst, bit creq, bit cwe, logic [31:0] caddr,
                              logic [31:0] cwd, bit dreq, bit dwe,
                              logic [31:0] daddr, logic [31:0] dwd,
                              bit stall, int gnt, bit dack);
    vec_t v;
    v.rst = rst;   v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe;   v.daddr = daddr; v.dwd = dwd;
    v.stall = stall; v.gnt = gnt; v.dack = dack;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s (vector %0d, t=%0t): got %h, expected %h", nm, nvec, $time, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    logic        exp_we;
    logic [31:0] exp_crd, exp_drd;
    sb_t         e;
    @(negedge CLK);
    RESET       = v.rst;
    bus.C_REQ   = v.creq;  bus.C_WE = v.cwe;  bus.C_ADDR = v.caddr;  bus.C_WDATA = v.cwd;
    bus.D_REQ   = v.dreq;  bus.D_WE = v.dwe;  bus.D_ADDR = v.daddr;  bus.D_WDATA = v.dwd;
    #1;
    nvec++;
    exp_crd = '0;
    exp_drd = '0;
    if (core_pend || dma_pend) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (!v.rst) begin
          if (e.is_core)    exp_crd = e.data;
          else if (e.is_rd) exp_drd = e.data;
        end
      end
    end
    exp_we = (v.gnt == 1) ? v.cwe : (v.gnt == 2) ? v.dwe : 1'b0;
    chk("C_STALL", bus.C_STALL, v.stall);
    chk("M_EN", bus.M_EN, (v.gnt != 0));
    chk("M_WE", bus.M_WE, exp_we);
    if (v.gnt != 0) begin
      chk("M_ADDR", bus.M_ADDR, (v.gnt == 1) ? v.caddr : v.daddr);
      if (exp_we) chk("M_WDATA", bus.M_WDATA, (v.gnt == 1) ? v.cwd : v.dwd);
    end
    chk("D_ACK", bus.D_ACK, v.dack);
    chk("C_RDATA", bus.C_RDATA, exp_crd);
    chk("D_RDATA", bus.D_RDATA, exp_drd);

    core_pend = (v.gnt == 1) && !v.cwe;
    dma_pend  = (v.gnt == 2);
    if (v.gnt == 1) begin
      if (v.cwe) ref_mem[v.caddr[9:2]] = v.cwd;
      else       sb.push_back('{is_core: 1'b1, is_rd: 1'b1, data: ref_mem[v.caddr[9:2]]});
    end else if (v.gnt == 2) begin
      if (v.dwe) begin
        ref_mem[v.daddr[9:2]] = v.dwd;
        sb.push_back('{is_core: 1'b0, is_rd: 1'b0, data: 32'h0});
      end else begin
        sb.push_back('{is_core: 1'b0, is_rd: 1'b1, data: ref_mem[v.daddr[9:2]]});
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl [$];
  vec_t v;

  initial begin
    RESET = 1'b1;
    bus.C_REQ = 1'b0; bus.C_WE = 1'b0; bus.C_ADDR = '0; bus.C_WDATA = '0;
    bus.D_REQ = 1'b0; bus.D_WE = 1'b0; bus.D_ADDR = '0; bus.D_WDATA = '0;

    //            rst creq cwe caddr   cwd           dreq dwe daddr   dwd           stall gnt dack
    tbl.push_back(mk(1, 1, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        1, 0, 0)); // reset: stall follows C_REQ
    tbl.push_back(mk(1, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 32'h00, 32'h0,        0, 1, 0)); // core write, no stall
    tbl.push_back(mk(0, 1, 1, 32'h44, 32'hCAFEF00D, 0, 0, 32'h00, 32'h0,        0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h40, 32'h0,        0, 0, 32'h00, 32'h0,        1, 1, 0)); // core read issue
    tbl.push_back(mk(0, 1, 0, 32'h40, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0)); // CORE_RD data
    tbl.push_back(mk(0, 0, 0, 32'h00, 32'h0,        1, 1, 32'h80, 32'h12345678, 0, 2, 0)); // DMA write
    tbl.push_back(mk(0, 0, 0, 32'h00, 32'h0,        1, 1, 32'h80, 32'h12345678, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h80, 32'h0,        0, 2, 0)); // DMA read
    tbl.push_back(mk(0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h80, 32'h0,        0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h44, 32'h0,        1, 0, 32'h40, 32'h0,        1, 1, 0)); // both: core wins
    tbl.push_back(mk(0, 1, 0, 32'h44, 32'h0,        1, 0, 32'h40, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h40, 32'h0,        0, 2, 0)); // DMA right after
    tbl.push_back(mk(0, 1, 1, 32'h48, 32'h11111111, 1, 0, 32'h40, 32'h0,        1, 0, 1)); // core stalled in DMA_DONE
    tbl.push_back(mk(0, 1, 1, 32'h48, 32'h11111111, 0, 0, 32'h00, 32'h0,        0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h48, 32'h0,        0, 2, 0));
    tbl.push_back(mk(1, 0, 0, 32'h00, 32'h0,        1, 0, 32'h48, 32'h0,        0, 0, 0)); // reset in DMA_DONE
    tbl.push_back(mk(0, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h48, 32'h0,        0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h48, 32'h0,        0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h48, 32'h0,        0, 0, 32'h00, 32'h0,        1, 1, 0));
    tbl.push_back(mk(1, 1, 0, 32'h48, 32'h0,        0, 0, 32'h00, 32'h0,        1, 0, 0)); // reset in CORE_RD
    tbl.push_back(mk(0, 1, 0, 32'h48, 32'h0,        0, 0, 32'h00, 32'h0,        1, 1, 0)); // reissued from IDLE
    tbl.push_back(mk(0, 1, 0, 32'h48, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

`ifdef DMEM_ARB_STARVE_EN
    // Back-to-back core writes with DMA held: forced grant on the 5th cycle,
    // twice, to show the wait count restarts from zero.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 7; k++) begin
        v = mk(0, 1, 1, 32'h100, 32'h1000 + r, (k <= 5), 1, 32'hC0, 32'hA5A50000 + r,
               (k == 4 || k == 5), (k < 4 || k == 6) ? 1 : (k == 4) ? 2 : 0, (k == 5));
        apply(v);
      end
    end
`else
    // Strict priority: DMA waits for as long as the core keeps requesting.
    for (int k = 0; k < 8; k++) begin
      v = mk(0, (k < 6), 1, 32'h100, 32'h1000, 1, 1, 32'hC0, 32'hA5A50000,
             0, (k < 6) ? 1 : (k == 6) ? 2 : 0, (k == 7));
      apply(v);
    end
`endif
    apply(mk(0, 0, 0, 32'h00, 32'h0, 0, 0, 32'h00, 32'h0, 0, 0, 0));
    apply(mk(0, 0, 0, 32'h00, 32'h0, 1, 0, 32'hC0, 32'h0, 0, 2, 0));
    apply(mk(0, 0, 0, 32'h00, 32'h0, 1, 0, 32'hC0, 32'h0, 0, 0, 1));
    apply(mk(0, 1, 0, 32'h100, 32'h0, 0, 0, 32'h00, 32'h0, 1, 1, 0));
    apply(mk(0, 1, 0, 32'h100, 32'h0, 0, 0, 32'h00, 32'h0, 0, 0, 0));
    apply(mk(0, 0, 0, 32'h00, 32'h0, 0, 0, 32'h00, 32'h0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
